// File: rtl/mips_mem_bridge.sv
// ============================================================================
// Module   : mips_mem_bridge
// Purpose  : Bridge between the multicycle MIPS core memory ports and a
//            single-port synchronous word RAM. Maps text/data byte addresses
//            to RAM word indices, sequences the RAM read latency, returns
//            read data with a valid strobe and flags faulting accesses.
// Ports    : clk, rstb (async active-low)
//            core_rd_req/core_rd_addr     - core read request
//            core_wr_ena/core_wr_addr/core_wr_data - core write request
//            core_rd_data/core_rd_valid   - read return (valid is a pulse)
//            core_busy                    - request in flight
//            core_err/err_sticky          - fault pulse / fault since reset
//            ram_addr/ram_wr_data/ram_wr_ena/ram_rd_data - RAM side
//            led                          - MMIO LED register
// Options  : define MIPS_MMIO_LED_EN to map word 32'hFFFF0000 to the LED
//            register; otherwise that address faults and led is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_bridge #(
  parameter int                N           = 32,
  parameter int                ADDR_W      = 10,
  parameter int                RAM_LATENCY = 2,
  parameter logic [N-1:0]      TEXT_BASE   = 32'h00400000,
  parameter logic [N-1:0]      DATA_BASE   = 32'h10010000
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              core_rd_req,
  input  logic [N-1:0]      core_rd_addr,
  input  logic              core_wr_ena,
  input  logic [N-1:0]      core_wr_addr,
  input  logic [N-1:0]      core_wr_data,
  output logic [N-1:0]      core_rd_data,
  output logic              core_rd_valid,
  output logic              core_busy,
  output logic              core_err,
  output logic              err_sticky,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [N-1:0]      ram_wr_data,
  output logic              ram_wr_ena,
  input  logic [N-1:0]      ram_rd_data,
  output logic [15:0]       led
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_RD_DONE = 3'd3;
  localparam logic [2:0] S_FAULT   = 3'd4;

  // Each region spans half the RAM: 2^(ADDR_W-1) words = 2^(ADDR_W+1) bytes.
  localparam logic [N-1:0] REGION_BYTES = N'(1) << (ADDR_W + 1);
  localparam logic [N-1:0] MMIO_ADDR    = N'(32'hFFFF0000);
  localparam logic [2:0]   LAST_CNT     = 3'(RAM_LATENCY - 1);

  // Decode result layout: {fault, mmio, word_index}.
  function automatic logic [ADDR_W+1:0] decode(input logic [N-1:0] a);
    logic [N-1:0]      t_off;
    logic [N-1:0]      d_off;
    logic [ADDR_W+1:0] r;
    t_off = a - TEXT_BASE;
    d_off = a - DATA_BASE;
    r     = {2'b10, {ADDR_W{1'b0}}};
    if (a[1:0] != 2'b00) begin
      r = {2'b10, {ADDR_W{1'b0}}};
    end else if ((a >= TEXT_BASE) && (t_off < REGION_BYTES)) begin
      r = {2'b00, 1'b0, t_off[ADDR_W:2]};
    end else if ((a >= DATA_BASE) && (d_off < REGION_BYTES)) begin
      r = {2'b00, 1'b1, d_off[ADDR_W:2]};
`ifdef MIPS_MMIO_LED_EN
    end else if (a == MMIO_ADDR) begin
      r = {2'b01, {ADDR_W{1'b0}}};
`endif
    end
    return r;
  endfunction

  logic [2:0]        r_state;
  logic [2:0]        r_cnt;
  logic [N-1:0]      r_wr_addr;
  logic [N-1:0]      r_wr_data;
  logic [N-1:0]      r_rd_addr;
  logic              r_rd_pend;
  logic              r_fault_rd;
  logic [N-1:0]      r_rd_data;
  logic              r_rd_valid;
  logic              r_err;
  logic              r_sticky;

  logic [ADDR_W+1:0] w_wr_dec;
  logic [ADDR_W+1:0] w_rd_dec;
  logic              w_wr_fault;
  logic              w_wr_mmio;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_rd_fault;
  logic              w_rd_mmio;
  logic [ADDR_W-1:0] w_rd_idx;
  logic [15:0]       w_led;

  assign w_wr_dec   = decode(r_wr_addr);
  assign w_rd_dec   = decode(r_rd_addr);
  assign w_wr_fault = w_wr_dec[ADDR_W+1];
  assign w_wr_mmio  = w_wr_dec[ADDR_W];
  assign w_wr_idx   = w_wr_dec[ADDR_W-1:0];
  assign w_rd_fault = w_rd_dec[ADDR_W+1];
  assign w_rd_mmio  = w_rd_dec[ADDR_W];
  assign w_rd_idx   = w_rd_dec[ADDR_W-1:0];

`ifdef MIPS_MMIO_LED_EN
  logic [15:0] r_led;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_led <= 16'h0000;
    end else if ((r_state == S_WRITE) && !w_wr_fault && w_wr_mmio) begin
      r_led <= r_wr_data[15:0];
    end
  end

  assign w_led = r_led;
`else
  assign w_led = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_addr  <= '0;
      r_rd_pend  <= 1'b0;
      r_fault_rd <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_sticky   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (core_wr_ena) begin
            r_wr_addr <= core_wr_addr;
            r_wr_data <= core_wr_data;
            r_state   <= S_WRITE;
            // A simultaneous read is parked until the write has retired so it
            // observes the freshly written word.
            if (core_rd_req) begin
              r_rd_addr <= core_rd_addr;
              r_rd_pend <= 1'b1;
            end
          end else if (core_rd_req) begin
            r_rd_addr <= core_rd_addr;
            r_cnt     <= 3'd0;
            r_state   <= S_RD_WAIT;
          end
        end
        S_WRITE: begin
          if (w_wr_fault) begin
            r_fault_rd <= 1'b0;
            r_state    <= S_FAULT;
          end else if (r_rd_pend) begin
            r_rd_pend <= 1'b0;
            r_cnt     <= 3'd0;
            r_state   <= S_RD_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD_WAIT: begin
          if (w_rd_fault) begin
            r_fault_rd <= 1'b1;
            r_state    <= S_FAULT;
          end else if (w_rd_mmio || (r_cnt == LAST_CNT)) begin
            r_state <= S_RD_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_RD_DONE: begin
          r_rd_data  <= w_rd_mmio ? {{(N-16){1'b0}}, w_led} : ram_rd_data;
          r_rd_valid <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_FAULT: begin
          r_err    <= 1'b1;
          r_sticky <= 1'b1;
          // A faulting read still completes with zero data so the core
          // never waits forever.
          if (r_fault_rd) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b1;
          end
          if (r_rd_pend) begin
            r_rd_pend <= 1'b0;
            r_cnt     <= 3'd0;
            r_state   <= S_RD_WAIT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr = '0;
    if ((r_state == S_WRITE) && !w_wr_fault && !w_wr_mmio) begin
      ram_addr = w_wr_idx;
    end else if (((r_state == S_RD_WAIT) || (r_state == S_RD_DONE)) &&
                 !w_rd_fault && !w_rd_mmio) begin
      ram_addr = w_rd_idx;
    end
  end

  assign ram_wr_ena    = (r_state == S_WRITE) && !w_wr_fault && !w_wr_mmio;
  assign ram_wr_data   = r_wr_data;
  assign core_busy     = (r_state != S_IDLE);
  assign core_rd_data  = r_rd_data;
  assign core_rd_valid = r_rd_valid;
  assign core_err      = r_err;
  assign err_sticky    = r_sticky;
  assign led           = w_led;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_bridge.sv
// ============================================================================
// Module   : tb_mips_mem_bridge
// Purpose  : Self-checking bench for mips_mem_bridge with a latency-2 RAM
//            model. Table of single transactions plus hand-written sequences
//            for busy-time request rejection and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_bridge;

  logic        clk = 1'b0;
  logic        rstb;
  logic        core_rd_req;
  logic [31:0] core_rd_addr;
  logic        core_wr_ena;
  logic [31:0] core_wr_addr;
  logic [31:0] core_wr_data;
  logic [31:0] core_rd_data;
  logic        core_rd_valid;
  logic        core_busy;
  logic        core_err;
  logic        err_sticky;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wr_data;
  logic        ram_wr_ena;
  logic [31:0] ram_rd_data;
  logic [15:0] led;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mips_mem_bridge dut (
    .clk          (clk),
    .rstb         (rstb),
    .core_rd_req  (core_rd_req),
    .core_rd_addr (core_rd_addr),
    .core_wr_ena  (core_wr_ena),
    .core_wr_addr (core_wr_addr),
    .core_wr_data (core_wr_data),
    .core_rd_data (core_rd_data),
    .core_rd_valid(core_rd_valid),
    .core_busy    (core_busy),
    .core_err     (core_err),
    .err_sticky   (err_sticky),
    .ram_addr     (ram_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_wr_ena   (ram_wr_ena),
    .ram_rd_data  (ram_rd_data),
    .led          (led)
  );

  // RAM model: two-stage read pipeline gives data two cycles after address.
  logic [31:0] mem [0:1023];
  logic [31:0] p1, p2;
  bit          init_done;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int j = 0; j < 1024; j++) mem[j] <= 32'h0;
      mem[1]    <= 32'h2008000A;
      mem[511]  <= 32'hCAFE0511;
      mem[1023] <= 32'hCAFE1023;
      init_done <= 1'b1;
    end else if (ram_wr_ena) begin
      mem[ram_addr] <= ram_wr_data;
    end
    p1 <= mem[ram_addr];
    p2 <= p1;
  end
  assign ram_rd_data = p2;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] raddr;
    int          exp_valid;
    int          exp_err;
    int          exp_wr;
    int          exp_busy;
    int          exp_lat;
    logic [31:0] exp_data;
    logic        chk_addr;
    logic [9:0]  exp_addr;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [31:0] wa,
                              input logic [31:0] wd, input logic rd,
                              input logic [31:0] ra, input int ev,
                              input int ee, input int ew, input int eb,
                              input int el, input logic [31:0] ed,
                              input logic ca, input logic [9:0] eaddr);
    vec_t v;
    v.wr = wr; v.waddr = wa; v.wdata = wd; v.rd = rd; v.raddr = ra;
    v.exp_valid = ev; v.exp_err = ee; v.exp_wr = ew; v.exp_busy = eb;
    v.exp_lat = el; v.exp_data = ed; v.chk_addr = ca; v.exp_addr = eaddr;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t vec [NV];

  int          n_valid, n_err, n_wr, n_busy, lat;
  logic [31:0] got_data, got_wdata;
  logic [9:0]  got_addr;

  // Watch the DUT for a fixed window of cycles after a request was sampled.
  task automatic observe(input int cycles);
    n_valid = 0; n_err = 0; n_wr = 0; n_busy = 0; lat = 0;
    got_data = 32'h0; got_wdata = 32'h0; got_addr = 10'h0;
    for (int k = 1; k <= cycles; k++) begin
      if (k == 1) got_addr = ram_addr;
      if (core_rd_valid) begin n_valid++; got_data = core_rd_data; lat = k; end
      if (core_err) n_err++;
      if (ram_wr_ena) begin n_wr++; got_wdata = ram_wr_data; end
      if (core_busy) n_busy++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] wa,
                       input logic [31:0] wd, input logic rd,
                       input logic [31:0] ra);
    core_wr_ena = wr; core_wr_addr = wa; core_wr_data = wd;
    core_rd_req = rd; core_rd_addr = ra;
    @(negedge clk);
    core_wr_ena = 1'b0; core_rd_req = 1'b0;
    core_wr_addr = 32'h0; core_rd_addr = 32'h0; core_wr_data = 32'h0;
  endtask

  initial begin
    vec[0]  = mk(0, 32'h0, 32'h0, 1, 32'h00400004, 1, 0, 0, 3, 4, 32'h2008000A, 1, 10'd1);
    vec[1]  = mk(1, 32'h10010008, 32'hDEADBEEF, 0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 1, 10'd514);
    vec[2]  = mk(0, 32'h0, 32'h0, 1, 32'h10010008, 1, 0, 0, 3, 4, 32'hDEADBEEF, 1, 10'd514);
    vec[3]  = mk(1, 32'h10010000, 32'h12345678, 1, 32'h10010000, 1, 0, 1, 4, 5, 32'h12345678, 1, 10'd512);
    vec[4]  = mk(0, 32'h0, 32'h0, 1, 32'h00400002, 1, 1, 0, 2, 3, 32'h0, 0, 10'd0);
    vec[5]  = mk(0, 32'h0, 32'h0, 1, 32'h20000000, 1, 1, 0, 2, 3, 32'h0, 0, 10'd0);
    vec[6]  = mk(0, 32'h0, 32'h0, 1, 32'h004007FC, 1, 0, 0, 3, 4, 32'hCAFE0511, 1, 10'd511);
    vec[7]  = mk(0, 32'h0, 32'h0, 1, 32'h00400800, 1, 1, 0, 2, 3, 32'h0, 0, 10'd0);
    vec[8]  = mk(0, 32'h0, 32'h0, 1, 32'h100107FC, 1, 0, 0, 3, 4, 32'hCAFE1023, 1, 10'd1023);
    vec[9]  = mk(0, 32'h0, 32'h0, 1, 32'h1000FFFC, 1, 1, 0, 2, 3, 32'h0, 0, 10'd0);
    vec[10] = mk(1, 32'h00400010, 32'h11111111, 0, 32'h0, 0, 0, 1, 1, 0, 32'h0, 1, 10'd4);
    vec[11] = mk(0, 32'h0, 32'h0, 1, 32'h00400010, 1, 0, 0, 3, 4, 32'h11111111, 1, 10'd4);
`ifdef MIPS_MMIO_LED_EN
    vec[12] = mk(1, 32'hFFFF0000, 32'h0000A5A5, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0, 10'd0);
    vec[13] = mk(0, 32'h0, 32'h0, 1, 32'hFFFF0000, 1, 0, 0, 2, 3, 32'h0000A5A5, 0, 10'd0);
`else
    vec[12] = mk(1, 32'hFFFF0000, 32'h0000A5A5, 0, 32'h0, 0, 1, 0, 2, 0, 32'h0, 0, 10'd0);
    vec[13] = mk(0, 32'h0, 32'h0, 1, 32'hFFFF0000, 1, 1, 0, 2, 3, 32'h0, 0, 10'd0);
`endif
    vec[14] = mk(1, 32'h20000000, 32'h00000077, 1, 32'h00400004, 1, 1, 0, 5, 6, 32'h2008000A, 0, 10'd0);

    rstb = 1'b0;
    core_rd_req = 1'b0; core_rd_addr = 32'h0;
    core_wr_ena = 1'b0; core_wr_addr = 32'h0; core_wr_data = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    n_vec++;
    chk("rst_rd_data", 0, core_rd_data, 32'h0);
    chk("rst_valid", 0, 32'(core_rd_valid), 32'h0);
    chk("rst_busy", 0, 32'(core_busy), 32'h0);
    chk("rst_err", 0, 32'(core_err), 32'h0);
    chk("rst_sticky", 0, 32'(err_sticky), 32'h0);
    chk("rst_ram_addr", 0, 32'(ram_addr), 32'h0);
    chk("rst_ram_we", 0, 32'(ram_wr_ena), 32'h0);
    chk("rst_led", 0, 32'(led), 32'h0);

    rstb = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      n_vec++;
      issue(vec[i].wr, vec[i].waddr, vec[i].wdata, vec[i].rd, vec[i].raddr);
      observe(12);
      chk("valid_cnt", i, 32'(n_valid), 32'(vec[i].exp_valid));
      if (vec[i].exp_valid != 0) begin
        chk("rd_data", i, got_data, vec[i].exp_data);
        chk("latency", i, 32'(lat), 32'(vec[i].exp_lat));
      end
      chk("err_cnt", i, 32'(n_err), 32'(vec[i].exp_err));
      chk("ram_we_cnt", i, 32'(n_wr), 32'(vec[i].exp_wr));
      if (vec[i].exp_wr != 0) chk("ram_wr_data", i, got_wdata, vec[i].wdata);
      chk("busy_cycles", i, 32'(n_busy), 32'(vec[i].exp_busy));
      if (vec[i].chk_addr) chk("ram_addr", i, 32'(got_addr), 32'(vec[i].exp_addr));
      if (i == 3) chk("sticky_clean", i, 32'(err_sticky), 32'h0);
      if (i == 4) chk("sticky_set", i, 32'(err_sticky), 32'h1);
    end

    n_vec++;
`ifdef MIPS_MMIO_LED_EN
    chk("led", 0, 32'(led), 32'h0000A5A5);
`else
    chk("led", 0, 32'(led), 32'h0);
`endif

    // Requests presented while busy must be ignored.
    n_vec++;
    core_rd_req = 1'b1; core_rd_addr = 32'h00400004;
    @(negedge clk);
    core_rd_req = 1'b1; core_rd_addr = 32'h004007FC;
    core_wr_ena = 1'b1; core_wr_addr = 32'h10010000; core_wr_data = 32'h55555555;
    chk("busy_hi", 0, 32'(core_busy), 32'h1);
    @(negedge clk);
    @(negedge clk);
    core_rd_req = 1'b0; core_wr_ena = 1'b0;
    core_rd_addr = 32'h0; core_wr_addr = 32'h0; core_wr_data = 32'h0;
    observe(10);
    chk("busy_ign_valid", 0, 32'(n_valid), 32'h1);
    chk("busy_ign_data", 0, got_data, 32'h2008000A);
    chk("busy_ign_we", 0, 32'(n_wr), 32'h0);

    // Asynchronous reset in the middle of a read.
    n_vec++;
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h100107FC);
    chk("pre_rst_busy", 0, 32'(core_busy), 32'h1);
    #2 rstb = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(core_busy), 32'h0);
    chk("arst_ram_addr", 0, 32'(ram_addr), 32'h0);
    chk("arst_rd_data", 0, core_rd_data, 32'h0);
    chk("arst_sticky", 0, 32'(err_sticky), 32'h0);
    chk("arst_led", 0, 32'(led), 32'h0);
    @(negedge clk);
    rstb = 1'b1;
    observe(8);
    chk("dropped_valid", 0, 32'(n_valid), 32'h0);
    chk("dropped_busy", 0, 32'(n_busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
